// File: rtl/ptos_frame_if.sv
// Bundles the parallel-source handshake and the serial scl/sda link of ptos_frame.
// master: the framer itself; slave: the source/receiver side.
interface ptos_frame_if #(
    parameter int DW = 4
);
    logic          en;
    logic [DW-1:0] data;
    logic          ask_for_data;
    logic          scl;
    logic          sda;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    modport master (
        input  en, data,
        output ask_for_data, scl, sda, busy, frame_done, frame_cnt
    );

    modport slave (
        output en, data,
        input  ask_for_data, scl, sda, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/ptos_frame.sv
// Parallel-to-serial framer: requests a word, then emits START, data MSB first,
// optional even parity (macro PTOS_PARITY_EN), STOP on scl/sda.
module ptos_frame #(
    parameter int DW       = 4,
    parameter int DATA_LAT = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic          sclk,
    input  logic          rst,
    ptos_frame_if.master  bus
);
    localparam int BW   = $clog2(DW + 1);
    localparam int CMAX = (DATA_LAT > GAP_CYC) ? DATA_LAT : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_START, ST_BIT, ST_PAR, ST_STOP, ST_GAP
    } state_t;

    function automatic logic bit_at(input logic [DW-1:0] word, input logic [BW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (BW'(i) == idx) r = word[i];
        end
        return r;
    endfunction

    function automatic logic even_parity(input logic [DW-1:0] word);
        return ^word;
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [BW-1:0] bit_r, bit_s;
    logic          phase_r, phase_s;
    logic [DW-1:0] shreg_r, shreg_s;
    logic [7:0]    frame_cnt_r, frame_cnt_s;
    logic          scl_r, sda_r, ask_r, busy_r, done_r;
    logic          scl_s, sda_s, ask_s, busy_s, done_s;

    // Next-state, counters and word latch.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_s       = bit_r;
        phase_s     = phase_r;
        shreg_s     = shreg_r;
        frame_cnt_s = frame_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.en) state_s = ST_REQ;
                else        state_s = ST_IDLE;
            end
            ST_REQ: begin
                state_s = ST_WAIT;
                cnt_s   = {CW{1'b0}};
            end
            ST_WAIT: begin
                if (cnt_r == CW'(DATA_LAT - 1)) begin
                    state_s = ST_START;
                    shreg_s = bus.data;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_START: begin
                state_s = ST_BIT;
                bit_s   = BW'(DW - 1);
                phase_s = 1'b0;
            end
            ST_BIT: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (bit_r == {BW{1'b0}}) begin
                    phase_s = 1'b0;
`ifdef PTOS_PARITY_EN
                    state_s = ST_PAR;
`else
                    state_s = ST_STOP;
`endif
                end else begin
                    phase_s = 1'b0;
                    bit_s   = bit_r - {{(BW-1){1'b0}}, 1'b1};
                end
            end
            ST_PAR: begin
`ifdef PTOS_PARITY_EN
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else begin
                    phase_s = 1'b0;
                    state_s = ST_STOP;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else begin
                    phase_s     = 1'b0;
                    state_s     = ST_GAP;
                    cnt_s       = {CW{1'b0}};
                    frame_cnt_s = frame_cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r == CW'(GAP_CYC - 1)) begin
                    if (bus.en) state_s = ST_REQ;
                    else        state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so the registers line up with state_r.
    always_comb begin
        scl_s  = 1'b1;
        sda_s  = 1'b1;
        ask_s  = 1'b0;
        busy_s = 1'b1;
        done_s = (state_s == ST_GAP) && (state_r == ST_STOP);
        case (state_s)
            ST_IDLE:  busy_s = 1'b0;
            ST_REQ:   ask_s  = 1'b1;
            ST_START: sda_s  = 1'b0;
            ST_BIT: begin
                scl_s = phase_s;
                sda_s = bit_at(shreg_s, bit_s);
            end
            ST_PAR: begin
                scl_s = phase_s;
                sda_s = even_parity(shreg_s);
            end
            ST_STOP: begin
                scl_s = phase_s;
                sda_s = 1'b0;
            end
            default: begin
                scl_s = 1'b1;
                sda_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame without a STOP.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_r       <= {BW{1'b0}};
            phase_r     <= 1'b0;
            shreg_r     <= {DW{1'b0}};
            frame_cnt_r <= 8'd0;
            scl_r       <= 1'b1;
            sda_r       <= 1'b1;
            ask_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_r       <= bit_s;
            phase_r     <= phase_s;
            shreg_r     <= shreg_s;
            frame_cnt_r <= frame_cnt_s;
            scl_r       <= scl_s;
            sda_r       <= sda_s;
            ask_r       <= ask_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.scl          = scl_r;
    assign bus.sda          = sda_r;
    assign bus.ask_for_data = ask_r;
    assign bus.busy         = busy_r;
    assign bus.frame_done   = done_r;
    assign bus.frame_cnt    = frame_cnt_r;
endmodule

// File: tb/tb_ptos_frame.sv
// Directed bench for ptos_frame: every cycle of every frame is compared against
// a hand-derived {ask, scl, sda, busy, frame_done, frame_cnt} vector.
module tb_ptos_frame;
    localparam int DW       = 4;
    localparam int DATA_LAT = 2;
    localparam int GAP_CYC  = 1;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_cnt = 8'd0;

    ptos_frame_if #(.DW(DW)) bus ();

    ptos_frame #(.DW(DW), .DATA_LAT(DATA_LAT), .GAP_CYC(GAP_CYC)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    function automatic logic [12:0] vec(input logic ask, input logic scl, input logic sda,
                                        input logic busy, input logic done, input logic [7:0] cnt);
        return {ask, scl, sda, busy, done, cnt};
    endfunction

    task automatic chk(input string tag, input logic [12:0] expv);
        logic [12:0] obs;
        obs = {bus.ask_for_data, bus.scl, bus.sda, bus.busy, bus.frame_done, bus.frame_cnt};
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (ask,scl,sda,busy,done,cnt[7:0])", tag, obs, expv);
        end
    endtask

    // mode 0: full frame; 1: drop en in the first bit; 2: pulse rst in the second bit and stop.
    task automatic run_frame(input logic [3:0] word, input int mode);
        @(negedge sclk);
        bus.data = word;
        chk("req", vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, exp_cnt));
        for (int w = 0; w < DATA_LAT; w++) begin
            @(negedge sclk);
            chk("wait", vec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, exp_cnt));
        end
        @(negedge sclk);
        bus.data = ~word;
        chk("start", vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt));
        for (int b = DW - 1; b >= 0; b--) begin
            @(negedge sclk);
            if (mode == 1 && b == DW - 1) bus.en = 1'b0;
            chk("bit_ph0", vec(1'b0, 1'b0, word[b], 1'b1, 1'b0, exp_cnt));
            if (mode == 2 && b == DW - 2) begin
                #1 rst = 1'b1;
                #1;
                exp_cnt = 8'd0;
                chk("rst_async", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt));
                return;
            end
            @(negedge sclk);
            chk("bit_ph1", vec(1'b0, 1'b1, word[b], 1'b1, 1'b0, exp_cnt));
        end
`ifdef PTOS_PARITY_EN
        @(negedge sclk);
        chk("par_ph0", vec(1'b0, 1'b0, ^word, 1'b1, 1'b0, exp_cnt));
        @(negedge sclk);
        chk("par_ph1", vec(1'b0, 1'b1, ^word, 1'b1, 1'b0, exp_cnt));
`endif
        @(negedge sclk);
        chk("stop_ph0", vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt));
        @(negedge sclk);
        chk("stop_ph1", vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge sclk);
            chk("gap", vec(1'b0, 1'b1, 1'b1, 1'b1, (g == 0) ? 1'b1 : 1'b0, exp_cnt));
        end
    endtask

    initial begin
        bus.en   = 1'b0;
        bus.data = 4'b0000;

        // Reset state, then idle with en low.
        @(negedge sclk);
        chk("in_reset", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        @(negedge sclk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            chk("idle_en0", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        end

        // Single frame 1010, then 16 back-to-back frames 0..15.
        bus.en = 1'b1;
        run_frame(4'b1010, 0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] w;
            w = 4'(i);
            run_frame(w, 0);
        end
        checks++;
        assert (bus.frame_cnt === 8'd17)
        else begin
            errors++;
            $error("FAIL cnt_after_17 observed=%0d expected=17", bus.frame_cnt);
        end

        // en dropped in the first bit: frame completes, then stays idle.
        run_frame(4'b1100, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge sclk);
            chk("idle_after_drop", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt));
        end

        // Reset pulse mid-frame, then restart from REQ.
        bus.en = 1'b1;
        run_frame(4'b0110, 2);
        @(negedge sclk);
        chk("held_reset", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        rst = 1'b0;
        run_frame(4'b1001, 0);

        // 255 more frames wrap the counter to 0; includes 0111 (odd weight).
        for (int i = 0; i < 255; i++) begin
            logic [3:0] w;
            w = 4'(i + 7);
            run_frame(w, 0);
        end
        checks++;
        assert (bus.frame_cnt === 8'd0)
        else begin
            errors++;
            $error("FAIL cnt_wrap observed=%0d expected=0", bus.frame_cnt);
        end

        bus.en = 1'b0;
        @(negedge sclk);
        chk("final_idle", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
